// File: rtl/fft_pkg.sv
// Shared FFT constants, word-type encoding and collector FSM state type.
package fft_pkg;

  localparam int unsigned FFT_PTS         = 32;
  localparam int unsigned WORDS_PER_FRAME = 64;
  localparam int unsigned ADDR_W          = $clog2(FFT_PTS);
  localparam int unsigned CNT_W           = $clog2(WORDS_PER_FRAME);
  localparam int unsigned FCNT_W          = 8;

  localparam logic TYPE_RE = 1'b0;
  localparam logic TYPE_IM = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/fft_out_collector_if.sv
// Serial FFT result stream from the transmitter into the collector.
interface fft_out_collector_if #(
  parameter int unsigned N = 16
);
  logic [N-1:0] serial_in;
  logic         in_valid;
  logic         in_type;
  logic         in_done;

  modport master (output serial_in, output in_valid, output in_type, output in_done);
  modport slave  (input  serial_in, input  in_valid, input  in_type, input  in_done);
endinterface

// File: rtl/collector_ram.sv
// 32 x 2N frame buffer: half-word write port, registered dual-half read port.
module collector_ram
  import fft_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wpart,
  input  logic [N-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [N-1:0]      rdata_r,
  output logic [N-1:0]      rdata_i
);

  logic [2*N-1:0] mem [FFT_PTS];

  // Buffer contents survive reset; imaginary part lives in the upper half.
  always_ff @(posedge clk2) begin
    if (we) begin
      if (wpart == TYPE_IM) mem[waddr][2*N-1:N] <= wdata;
      else                  mem[waddr][N-1:0]   <= wdata;
    end
  end

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      rdata_r <= '0;
      rdata_i <= '0;
    end else begin
      rdata_r <= mem[raddr][N-1:0];
      rdata_i <= mem[raddr][2*N-1:N];
    end
  end

endmodule

// File: rtl/fft_out_collector.sv
// Collects a 64-word interleaved re/im FFT frame into a buffer and holds it until acked.
module fft_out_collector
  import fft_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned Q = 8
) (
  input  logic              clk2,
  input  logic              rst,
  fft_out_collector_if.slave tx,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [N-1:0]      rd_data_r,
  output logic [N-1:0]      rd_data_i,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              err_seq,
  output logic              err_short,
  output logic              err_ovf,
  output logic [FCNT_W-1:0] frame_cnt
);

  if (Q >= N) begin : g_bad_q
    $error("fft_out_collector: Q must be smaller than N");
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FCNT_W-1:0]   fcnt_d;
  logic                ready_d, seq_d, short_d, ovf_d;
  logic                we;
  logic [ADDR_W-1:0]   wbin;
  logic                wpart;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = frame_cnt;
    ready_d = frame_ready;
    seq_d   = 1'b0;
    short_d = 1'b0;
    ovf_d   = 1'b0;
    we      = 1'b0;
    wbin    = cnt_q[CNT_W-1:1];
    wpart   = cnt_q[0];

    unique case (state_q)
      IDLE: begin
        if (tx.in_valid) begin
          if (tx.in_type == TYPE_RE) begin
            we      = 1'b1;
            wbin    = '0;
            wpart   = TYPE_RE;
            cnt_d   = CNT_W'(1);
            state_d = COLLECT;
          end else begin
            seq_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (tx.in_valid) begin
          if (tx.in_type != cnt_q[0]) begin
            // Out-of-order word: drop partial frame, a real part restarts as r0.
            seq_d = 1'b1;
            if (tx.in_type == TYPE_RE) begin
              we    = 1'b1;
              wbin  = '0;
              wpart = TYPE_RE;
              cnt_d = CNT_W'(1);
            end else begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            we = 1'b1;
            if (cnt_q == CNT_W'(WORDS_PER_FRAME - 1)) begin
              cnt_d   = '0;
              ready_d = 1'b1;
              fcnt_d  = frame_cnt + FCNT_W'(1);
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        if (tx.in_done && state_d != HOLD) begin
          short_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      HOLD: begin
        if (frame_ack) begin
          // Ack releases the frame first, so a coincident word is seen as in IDLE.
          ready_d = 1'b0;
          state_d = IDLE;
          if (tx.in_valid) begin
            if (tx.in_type == TYPE_RE) begin
              we      = 1'b1;
              wbin    = '0;
              wpart   = TYPE_RE;
              cnt_d   = CNT_W'(1);
              state_d = COLLECT;
            end else begin
              seq_d = 1'b1;
            end
          end
        end else if (tx.in_valid) begin
          ovf_d = 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_ready <= 1'b0;
      err_seq     <= 1'b0;
      err_short   <= 1'b0;
      err_ovf     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_ready <= ready_d;
      err_seq     <= seq_d;
      err_short   <= short_d;
      err_ovf     <= ovf_d;
      frame_cnt   <= fcnt_d;
    end
  end

  collector_ram #(.N(N)) u_ram (
    .clk2    (clk2),
    .rst     (rst),
    .we      (we),
    .waddr   (wbin),
    .wpart   (wpart),
    .wdata   (tx.serial_in),
    .raddr   (rd_addr),
    .rdata_r (rd_data_r),
    .rdata_i (rd_data_i)
  );

endmodule

// File: tb/tb_fft_out_collector.sv
// Directed self-checking bench for fft_out_collector.
module tb_fft_out_collector;

  logic        clk2;
  logic        rst;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data_r, rd_data_i;
  logic        frame_ready, frame_ack;
  logic        err_seq, err_short, err_ovf;
  logic [7:0]  frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_seq = 0;
  int n_short = 0;
  int n_ovf = 0;

  fft_out_collector_if #(.N(16)) tx_if ();

  fft_out_collector #(.N(16), .Q(8)) dut (
    .clk2        (clk2),
    .rst         (rst),
    .tx          (tx_if.slave),
    .rd_addr     (rd_addr),
    .rd_data_r   (rd_data_r),
    .rd_data_i   (rd_data_i),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .err_seq     (err_seq),
    .err_short   (err_short),
    .err_ovf     (err_ovf),
    .frame_cnt   (frame_cnt)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  // Error pulse tally, sampled shortly after each active edge.
  always @(posedge clk2) begin
    #2;
    if (err_seq)   n_seq++;
    if (err_short) n_short++;
    if (err_ovf)   n_ovf++;
  end

  task automatic drive(input logic v, input logic t, input logic [15:0] d,
                       input logic done, input logic ack);
    tx_if.in_valid  = v;
    tx_if.in_type   = t;
    tx_if.serial_in = d;
    tx_if.in_done   = done;
    frame_ack       = ack;
    @(negedge clk2);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  // Words first..last of a frame with r_k = base+k, i_k = -(base+k).
  task automatic send_words(input int base, input int first, input int last);
    for (int w = first; w <= last; w++) begin
      if (w % 2 == 0) drive(1'b1, 1'b0, 16'(base + w / 2), 1'b0, 1'b0);
      else            drive(1'b1, 1'b1, 16'(-(base + w / 2)), 1'b0, 1'b0);
    end
  endtask

  task automatic read_bin(input logic [4:0] a, output logic [15:0] r, output logic [15:0] i);
    rd_addr = a;
    idle();
    r = rd_data_r;
    i = rd_data_i;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_addr = 5'd0;
    tx_if.in_valid = 1'b0; tx_if.in_type = 1'b0; tx_if.in_done = 1'b0;
    tx_if.serial_in = 16'h0; frame_ack = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk2);
    @(negedge clk2);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", frame_ready); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_fcnt: got %0d want 0", frame_cnt); end
    n_cmp++; if ({err_seq, err_short, err_ovf} !== 3'b000) begin n_bad++; $display("FAIL reset_err: got %b want 000", {err_seq, err_short, err_ovf}); end
    n_cmp++; if ({rd_data_r, rd_data_i} !== 32'h0) begin n_bad++; $display("FAIL reset_rd: got %h want 0", {rd_data_r, rd_data_i}); end
    rst = 1'b1;
    idle();
  endtask

  task automatic test_full_frame();
    int s0, sh0, o0;
    logic [15:0] r, i;
    s0 = n_seq; sh0 = n_short; o0 = n_ovf;
    send_words(0, 0, 62);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL ff_ready_early: got %b want 0", frame_ready); end
    send_words(0, 63, 63);
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL ff_ready: got %b want 1", frame_ready); end
    n_cmp++; if (frame_cnt !== 8'd1) begin n_bad++; $display("FAIL ff_fcnt: got %0d want 1", frame_cnt); end
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL ff_done_in_hold: got %b want 1", frame_ready); end
    n_cmp++; if ((n_seq - s0) != 0 || (n_short - sh0) != 0 || (n_ovf - o0) != 0) begin
      n_bad++; $display("FAIL ff_no_err: got seq=%0d short=%0d ovf=%0d want 0", n_seq - s0, n_short - sh0, n_ovf - o0); end
    read_bin(5'd5, r, i);
    n_cmp++; if (r !== 16'd5 || i !== 16'hFFFB) begin n_bad++; $display("FAIL ff_bin5: got %h/%h want 0005/fffb", r, i); end
    read_bin(5'd0, r, i);
    n_cmp++; if (r !== 16'd0 || i !== 16'd0) begin n_bad++; $display("FAIL ff_bin0: got %h/%h want 0000/0000", r, i); end
    read_bin(5'd31, r, i);
    n_cmp++; if (r !== 16'd31 || i !== 16'hFFE1) begin n_bad++; $display("FAIL ff_bin31: got %h/%h want 001f/ffe1", r, i); end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL ff_ack: got %b want 0", frame_ready); end
    idle();
  endtask

  task automatic test_short();
    int sh0;
    logic [15:0] r, i;
    sh0 = n_short;
    send_words(50, 0, 19);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle();
    n_cmp++; if ((n_short - sh0) != 1) begin n_bad++; $display("FAIL short_pulse: got %0d want 1", n_short - sh0); end
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL short_ready: got %b want 0", frame_ready); end
    // A fresh frame must complete at exactly 64 words, proving the count restarted.
    send_words(100, 0, 63);
    n_cmp++; if (frame_ready !== 1'b1 || frame_cnt !== 8'd2) begin
      n_bad++; $display("FAIL short_next_frame: got ready=%b cnt=%0d want 1/2", frame_ready, frame_cnt); end
    read_bin(5'd7, r, i);
    n_cmp++; if (r !== 16'd107 || i !== 16'(-107)) begin n_bad++; $display("FAIL short_bin7: got %h/%h want 006b/ff95", r, i); end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    idle();
  endtask

  task automatic test_seq();
    int s0;
    logic [15:0] r, i;
    s0 = n_seq;
    drive(1'b1, 1'b0, 16'd500, 1'b0, 1'b0);
    send_words(600, 0, 0);
    n_cmp++; if ((n_seq - s0) != 1) begin n_bad++; $display("FAIL seq_pulse: got %0d want 1", n_seq - s0); end
    send_words(600, 1, 62);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL seq_ready_early: got %b want 0", frame_ready); end
    send_words(600, 63, 63);
    n_cmp++; if (frame_ready !== 1'b1 || frame_cnt !== 8'd3) begin
      n_bad++; $display("FAIL seq_complete: got ready=%b cnt=%0d want 1/3", frame_ready, frame_cnt); end
    read_bin(5'd0, r, i);
    n_cmp++; if (r !== 16'd600 || i !== 16'(-600)) begin n_bad++; $display("FAIL seq_bin0: got %h/%h want 0258/fda8", r, i); end
    read_bin(5'd31, r, i);
    n_cmp++; if (r !== 16'd631 || i !== 16'(-631)) begin n_bad++; $display("FAIL seq_bin31: got %h/%h want 0277/fd89", r, i); end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    idle();
    n_cmp++; if ((n_seq - s0) != 1) begin n_bad++; $display("FAIL seq_total: got %0d want 1", n_seq - s0); end
  endtask

  task automatic test_hold_ovf();
    int o0;
    logic [15:0] r, i;
    send_words(1000, 0, 63);
    o0 = n_ovf;
    drive(1'b1, 1'b0, 16'h7777, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'h7777, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h7777, 1'b0, 1'b0);
    idle();
    n_cmp++; if ((n_ovf - o0) != 3) begin n_bad++; $display("FAIL ovf_pulses: got %0d want 3", n_ovf - o0); end
    n_cmp++; if (frame_ready !== 1'b1 || frame_cnt !== 8'd4) begin
      n_bad++; $display("FAIL ovf_hold: got ready=%b cnt=%0d want 1/4", frame_ready, frame_cnt); end
    read_bin(5'd0, r, i);
    n_cmp++; if (r !== 16'd1000 || i !== 16'(-1000)) begin n_bad++; $display("FAIL ovf_bin0: got %h/%h want 03e8/fc18", r, i); end
    read_bin(5'd1, r, i);
    n_cmp++; if (r !== 16'd1001 || i !== 16'(-1001)) begin n_bad++; $display("FAIL ovf_bin1: got %h/%h want 03e9/fc17", r, i); end
    drive(1'b1, 1'b0, 16'd42, 1'b0, 1'b1);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL ack_word_ready: got %b want 0", frame_ready); end
    send_words(42, 1, 63);
    n_cmp++; if ((n_ovf - o0) != 3) begin n_bad++; $display("FAIL ack_word_ovf: got %0d want 3", n_ovf - o0); end
    n_cmp++; if (frame_ready !== 1'b1 || frame_cnt !== 8'd5) begin
      n_bad++; $display("FAIL ack_word_frame: got ready=%b cnt=%0d want 1/5", frame_ready, frame_cnt); end
    read_bin(5'd0, r, i);
    n_cmp++; if (r !== 16'd42 || i !== 16'(-42)) begin n_bad++; $display("FAIL ack_word_bin0: got %h/%h want 002a/ffd6", r, i); end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    idle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] r, i;
    rd_addr = 5'd2;
    send_words(300, 0, 39);
    tx_if.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++; if (frame_ready !== 1'b0 || frame_cnt !== 8'd0) begin
      n_bad++; $display("FAIL rstmid_state: got ready=%b cnt=%0d want 0/0", frame_ready, frame_cnt); end
    n_cmp++; if ({err_seq, err_short, err_ovf} !== 3'b000 || {rd_data_r, rd_data_i} !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_outs: got err=%b rd=%h want 000/0", {err_seq, err_short, err_ovf}, {rd_data_r, rd_data_i}); end
    @(negedge clk2);
    rst = 1'b1;
    idle();
    send_words(7, 0, 63);
    n_cmp++; if (frame_ready !== 1'b1 || frame_cnt !== 8'd1) begin
      n_bad++; $display("FAIL rstmid_frame: got ready=%b cnt=%0d want 1/1", frame_ready, frame_cnt); end
    read_bin(5'd3, r, i);
    n_cmp++; if (r !== 16'd10 || i !== 16'(-10)) begin n_bad++; $display("FAIL rstmid_bin3: got %h/%h want 000a/fff6", r, i); end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    idle();
  endtask

  task automatic test_wrap();
    for (int f = 0; f < 254; f++) begin
      send_words(2000 + f, 0, 63);
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    end
    idle();
    n_cmp++; if (frame_cnt !== 8'd255) begin n_bad++; $display("FAIL wrap_255: got %0d want 255", frame_cnt); end
    send_words(5000, 0, 63);
    n_cmp++; if (frame_cnt !== 8'd0 || frame_ready !== 1'b1) begin
      n_bad++; $display("FAIL wrap_0: got cnt=%0d ready=%b want 0/1", frame_cnt, frame_ready); end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    idle();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short();
    test_seq();
    test_hold_ovf();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_out_collector.md
FFT_OUT_COLLECTOR -- requirements
Module: fft_out_collector

Interface
REQ-001 Parameter N, default 16, sample word width in bits (signed fixed point).
REQ-002 Parameter Q, default 8, fractional bits; carried only for format consistency and not used in the datapath.
REQ-003 Port clk2, input, 1, the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port serial_in, input, N, serial FFT result word from the transmitter serial_out.
REQ-006 Port in_valid, input, 1, qualifies serial_in for the current cycle.
REQ-007 Port in_type, input, 1, word type: 0 = real part, 1 = imaginary part.
REQ-008 Port in_done, input, 1, one-cycle end-of-frame strobe from the transmitter.
REQ-009 Port rd_addr, input, 5, bin index to read (0..31).
REQ-010 Port rd_data_r, output, N, real part of the selected bin, registered.
REQ-011 Port rd_data_i, output, N, imaginary part of the selected bin, registered.
REQ-012 Port frame_ready, output, 1, a complete 32-bin frame is held and readable.
REQ-013 Port frame_ack, input, 1, one-cycle pulse that releases the held frame.
REQ-014 Port err_seq, output, 1, one-cycle pulse on a word-type order violation.
REQ-015 Port err_short, output, 1, one-cycle pulse when in_done arrives before 64 words.
REQ-016 Port err_ovf, output, 1, one-cycle pulse when a word arrives while a frame is held.
REQ-017 Port frame_cnt, output, 8, count of completed frames, wraps 255 -> 0.

Function
REQ-018 Frame protocol: 64 valid words in the order r0,i0,r1,i1,...,r31,i31; in_type must alternate 0,1 starting with 0.
REQ-019 FSM states: IDLE, COLLECT, HOLD.
REQ-020 IDLE -> COLLECT on a valid word with in_type=0; that word is stored as r0.
REQ-021 In IDLE, a valid word with in_type=1 is dropped and pulses err_seq.
REQ-022 In COLLECT, a 6-bit word counter selects the destination: bin = cnt[5:1], part = cnt[0].
REQ-023 In COLLECT, on a type mismatch the partial frame is discarded and err_seq pulses; a mismatching word with in_type=0 restarts as r0 (stay in COLLECT, cnt=1); otherwise go to IDLE.
REQ-024 Storing the 64th word moves COLLECT -> HOLD, raises frame_ready on the next cycle, and increments frame_cnt.
REQ-025 In COLLECT, in_done with fewer than 64 words pulses err_short and returns to IDLE; in_done in HOLD or IDLE is ignored.
REQ-026 In HOLD, valid words pulse err_ovf and are dropped; buffer contents are frozen.
REQ-027 frame_ack in HOLD clears frame_ready on the next cycle and returns to IDLE; frame_ack in any other state is ignored.
REQ-028 If frame_ack and a valid type-0 word coincide in HOLD, the ack takes effect first: the word is stored as r0, the state becomes COLLECT, and err_ovf does not pulse.
REQ-029 Read port: rd_data_r/rd_data_i reflect rd_addr with 1-cycle latency in every state; data is meaningful only while frame_ready=1.
REQ-030 The buffer is 32 x 2N bits, written only by the collector; there is no arithmetic or width change.

Reset
REQ-031 Asserting rst forces state IDLE, cnt 0, frame_ready 0, all err_* 0, frame_cnt 0, rd_data_r/rd_data_i 0 immediately, and discards any partial frame.
REQ-032 Buffer contents are not reset.

Structure
REQ-033 The shared fft_pkg holds FFT_PTS=32, WORDS_PER_FRAME=64, the type encoding constants, and the FSM state typedef.
REQ-034 One sub-module, collector_ram: 32 x 2N bits, one write port and one registered read port.

Verification
REQ-035 Feed r_k=k and i_k=-k for k=0..31, then in_done -> frame_ready=1, frame_cnt=1, rd_addr=5 gives r=5, i=-5 one cycle later.
REQ-036 Send 20 words, then in_done -> err_short pulse, frame_ready stays 0, state returns to IDLE.
REQ-037 Send r0 followed by r1 (type 0 twice) -> err_seq pulse, counter restarts with r1 stored as r0, and a subsequent 63 words complete the frame.
REQ-038 In HOLD, send 3 words -> three err_ovf pulses and the buffer is unchanged; then frame_ack coinciding with a type-0 word -> no err_ovf, state becomes COLLECT.
REQ-039 Assert rst after 40 words -> all outputs zero; a following full frame completes normally with frame_cnt=1.
REQ-040 Complete 256 frames -> frame_cnt wraps to 0.
